// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - multi-digit 7-segment controller with enable, leading-zero blanking and blink
// Segments are registered from the stored value, the current blink phase and the live control inputs.
module hex_display_ctrl #(
   parameter int DIGITS    = 6,
   parameter int BLINK_DIV = 25000000
) (
   input  logic                  i_clk,
   input  logic                  i_clrn,
   input  logic                  i_load,
   input  logic [4*DIGITS-1:0]   i_value,
   input  logic [DIGITS-1:0]     i_digit_en,
   input  logic [DIGITS-1:0]     i_blink_mask,
   input  logic                  i_lz_suppress,
   output logic [7*DIGITS-1:0]   o_segs,
   output logic                  o_blink_phase
);

   localparam int            CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

   logic [4*DIGITS-1:0] r_value;
   logic [CW-1:0]       r_cnt;
   logic                r_phase;
   logic [7*DIGITS-1:0] r_segs;
   logic [7*DIGITS-1:0] w_next_segs;
   logic [DIGITS-1:0]   w_supp;
   logic                w_zero_run;
   logic                w_wrap;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign w_wrap = (r_cnt == CNT_MAX);

   always_ff @(posedge i_clk or negedge i_clrn) begin
      if (!i_clrn) begin
         r_value <= '0;
         r_cnt   <= '0;
         r_phase <= 1'b0;
         r_segs  <= '1;
      end else begin
         if (i_load)
            r_value <= i_value;
         if (w_wrap) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
         end else begin
            r_cnt   <= r_cnt + CW'(1);
         end
         r_segs <= w_next_segs;
      end
   end

   // Zero run is accumulated from the most significant digit downward.
   always_comb begin
      w_supp      = '0;
      w_next_segs = '1;
      w_zero_run  = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_run = w_zero_run & (r_value[4*i +: 4] == 4'h0);
         w_supp[i]  = i_lz_suppress & w_zero_run & (i != 0);
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (!i_digit_en[i] || w_supp[i] || (i_blink_mask[i] && r_phase))
            w_next_segs[7*i +: 7] = 7'h7F;
         else
            w_next_segs[7*i +: 7] = f_decode(r_value[4*i +: 4]);
      end
   end

   assign o_segs        = r_segs;
   assign o_blink_phase = r_phase;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed self-checking bench for hex_display_ctrl
// Six digits, blink half-period of four cycles, hand-computed segment patterns.
module tb_hex_display_ctrl;

   logic        clk;
   logic        clrn;
   logic        load;
   logic [23:0] value;
   logic [5:0]  digit_en;
   logic [5:0]  blink_mask;
   logic        lz_suppress;
   logic [41:0] segs;
   logic        blink_phase;

   int checks   = 0;
   int failures = 0;

   localparam logic [41:0] ALL_BLANK = {6{7'h7F}};
   localparam logic [41:0] ALL_ZERO  = {6{7'h40}};

   logic [6:0] exp_d0 [1:21] = '{7'h40, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h7F, 7'h7F,
                                 7'h7F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h7F, 7'h7F,
                                 7'h7F, 7'h7F, 7'h12, 7'h12, 7'h12, 7'h12, 7'h7F};
   logic       exp_ph [1:21] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
   logic [6:0] rst_d0 [1:5]  = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h7F};
   logic       rst_ph [1:5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   hex_display_ctrl #(.DIGITS(6), .BLINK_DIV(4)) dut (
      .i_clk         (clk),
      .i_clrn        (clrn),
      .i_load        (load),
      .i_value       (value),
      .i_digit_en    (digit_en),
      .i_blink_mask  (blink_mask),
      .i_lz_suppress (lz_suppress),
      .o_segs        (segs),
      .o_blink_phase (blink_phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_segs(input string tag, input logic [41:0] got, input logic [41:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s segs got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_phase(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s phase got=%b exp=%b", tag, got, exp);
      end
   endtask

   initial begin
      clrn        = 1'b0;
      load        = 1'b1;
      value       = 24'h123456;
      digit_en    = 6'h3F;
      blink_mask  = 6'h00;
      lz_suppress = 1'b0;
      #1;
      tick();
      tick();
      chk_segs("reset_blank", segs, ALL_BLANK);
      chk_phase("reset_phase", blink_phase, 1'b0);

      clrn = 1'b1;
      load = 1'b0;
      tick();
      tick();
      chk_segs("after_release_zero", segs, ALL_ZERO);

      value = 24'h0A1B2C;
      load  = 1'b1;
      tick();
      chk_segs("load_latency", segs, ALL_ZERO);
      load = 1'b0;
      tick();
      chk_segs("load_0A1B2C", segs, {7'h40, 7'h08, 7'h79, 7'h03, 7'h24, 7'h46});
      value = 24'hFFFFFF;
      tick();
      tick();
      chk_segs("no_load_hold", segs, {7'h40, 7'h08, 7'h79, 7'h03, 7'h24, 7'h46});

      value       = 24'h000070;
      load        = 1'b1;
      lz_suppress = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk_segs("lz_000070", segs, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h40});
      lz_suppress = 1'b0;
      tick();
      chk_segs("nolz_000070", segs, {7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h40});

      value       = 24'h000000;
      load        = 1'b1;
      lz_suppress = 1'b1;
      tick();
      load = 1'b0;
      tick();
      chk_segs("lz_zero", segs, {{5{7'h7F}}, 7'h40});

      value       = 24'h000008;
      load        = 1'b1;
      lz_suppress = 1'b0;
      digit_en    = 6'h3E;
      tick();
      load = 1'b0;
      tick();
      chk_segs("en_3E", segs, {{5{7'h40}}, 7'h7F});
      lz_suppress = 1'b1;
      blink_mask  = 6'h01;
      tick();
      chk_segs("en_3E_lz_blink", segs, ALL_BLANK);

      clrn        = 1'b0;
      digit_en    = 6'h3F;
      blink_mask  = 6'h01;
      lz_suppress = 1'b0;
      value       = 24'h000008;
      load        = 1'b1;
      #1;
      chk_segs("reset2_blank", segs, ALL_BLANK);
      chk_phase("reset2_phase", blink_phase, 1'b0);
      tick();
      clrn = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         if (k == 2)  load = 1'b0;
         if (k == 12) begin
            value = 24'h000005;
            load  = 1'b1;
         end
         if (k == 13) load = 1'b0;
         tick();
         chk_segs($sformatf("blink_e%0d", k), segs, {{5{7'h40}}, exp_d0[k]});
         chk_phase($sformatf("blink_e%0d", k), blink_phase, exp_ph[k]);
      end

      clrn = 1'b0;
      #1;
      chk_segs("midblink_reset_blank", segs, ALL_BLANK);
      chk_phase("midblink_reset_phase", blink_phase, 1'b0);
      tick();
      clrn = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_segs($sformatf("restart_e%0d", k), segs, {{5{7'h40}}, rst_d0[k]});
         chk_phase($sformatf("restart_e%0d", k), blink_phase, rst_ph[k]);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
